// File: rtl/serial_adder.sv
// Bit-serial adder: one shared full-adder cell with a registered carry, one bit per clock.
// Operands are captured on an accepted start; sum/cout are updated only when the result completes.
//
//   state | meaning
//   IDLE  | waiting for start; sum/cout hold the last result
//   SHIFT | one operand bit pair added per edge, LSB first
//   DONE  | result valid, done pulses for one cycle
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             carry;
  logic [CW-1:0]    count;
  logic             s_bit;
  logic             c_bit;
  logic             last;

  // full-adder cell shared by every bit position
  assign s_bit = sa[0] ^ sb[0] ^ carry;
  assign c_bit = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
  assign last  = (count == CW'(WIDTH - 1));

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            count <= '0;
            sr    <= '0;
          end
        end
        SHIFT: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          carry <= c_bit;
          sr    <= {s_bit, sr[WIDTH-1:1]};
          count <= count + CW'(1);
          if (last) begin
            sum  <= {s_bit, sr[WIDTH-1:1]};
            cout <= c_bit;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=4 against an arithmetic reference
// ({cout,sum} = a+b+cin) and the start-to-done cycle timing.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;
  logic       cin8, cin4;
  logic       busy8, done8, cout8, busy4, done4, cout4;
  logic [7:0] sum8;
  logic [3:0] sum4;

  int vectors     = 0;
  int miscompares = 0;
  logic use4 = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  wire        o_busy = use4 ? busy4 : busy8;
  wire        o_done = use4 ? done4 : done8;
  wire [8:0]  o_res  = use4 ? {4'b0, cout4, sum4} : {cout8, sum8};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete addition: start accepted at E0, done expected in the cycle after E_w.
  task automatic op(input int w, input logic [7:0] aa, input logic [7:0] bb, input logic cc);
    int k;
    int ref_sum;
    ref_sum = (w == 4) ? ((int'(aa[3:0]) + int'(bb[3:0]) + int'(cc)) & 32'h1F)
                       : ((int'(aa) + int'(bb) + int'(cc)) & 32'h1FF);
    use4 = (w == 4);
    @(negedge clk);
    if (w == 4) begin a4 = aa[3:0]; b4 = bb[3:0]; cin4 = cc; start4 = 1'b1; end
    else        begin a8 = aa;      b8 = bb;      cin8 = cc; start8 = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
    chk("busy_after_start", 32'(o_busy), 32'd1);
    k = 0;
    while (!o_done && k < w + 4) begin
      @(negedge clk);
      k++;
    end
    chk("done_latency", k, w);
    chk("result", 32'(o_res), ref_sum);
    chk("busy_in_done", 32'(o_busy), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(o_done), 32'd0);
    chk("busy_back_idle", 32'(o_busy), 32'd0);
  endtask

  initial begin
    int dcount;
    int last_pos;
    logic [8:0] got;
    rst = 1'b1;
    start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0;
    a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_res8",  32'({cout8, sum8}), 32'd0);
    chk("rst_res4",  32'({busy4, done4, cout4, sum4}), 32'd0);
    rst = 1'b0;

    op(8, 8'h00, 8'h00, 1'b0);
    op(8, 8'hFF, 8'h01, 1'b0);
    op(8, 8'hA5, 8'h5A, 1'b1);
    op(8, 8'h3C, 8'h42, 1'b0);

    // operands change and start pulses while busy: exactly one result, from the captured operands
    use4 = 1'b0;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    dcount = 0;
    got = '0;
    for (int i = 0; i < 8 + 6; i++) begin
      @(negedge clk);
      if (done8) begin dcount++; got = {cout8, sum8}; end
      if (i < 8) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); start8 = 1'($urandom);
      end else begin
        start8 = 1'b0;
      end
    end
    chk("ignored_start_dones", dcount, 1);
    chk("ignored_start_result", 32'(got), 32'h030);
    chk("ignored_start_idle", 32'(busy8), 32'd0);

    // reset during the 4th SHIFT cycle aborts the operation
    @(negedge clk);
    a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_result", 32'({cout8, sum8}), 32'd0);
    op(8, 8'h01, 8'h01, 1'b0);

    // start held high: back-to-back additions every WIDTH+2 cycles
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    dcount = 0;
    last_pos = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done8) begin
        dcount++;
        chk("hold_result", 32'({cout8, sum8}), 32'h100);
        if (last_pos >= 0) chk("hold_spacing", i - last_pos, 10);
        else               chk("hold_first_done", i, 8);
        last_pos = i;
      end
    end
    start8 = 1'b0;
    chk("hold_done_count", dcount, 4);
    repeat (12) @(negedge clk);

    for (int i = 0; i < 20; i++)
      op(8, 8'($urandom), 8'($urandom), 1'($urandom));

    for (int c = 0; c < 2; c++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          op(4, 8'(x), 8'(y), 1'(c));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
